// File: rtl/riscv_ifetch_biu.sv
// riscv_ifetch_biu: in-order instruction-fetch bus interface with PC-tagged parcel FIFO and flush discard.
// Define RISCV_IFETCH_BYPASS_EN to present a response arriving at an empty FIFO in the same cycle.
module riscv_ifetch_biu #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200,
  parameter int PARCEL_SIZE = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [XLEN-1:0]          if_nxt_pc,
  input  logic                     if_stall,
  input  logic                     if_flush,
  output logic                     if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]   if_parcel,
  output logic [XLEN-1:0]          if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                     if_parcel_misaligned,
  output logic                     if_parcel_page_fault,
  output logic                     ibus_req,
  output logic [XLEN-1:0]          ibus_addr,
  input  logic                     ibus_gnt,
  input  logic                     ibus_rvalid,
  input  logic [PARCEL_SIZE-1:0]   ibus_rdata,
  input  logic                     ibus_err
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int NV = PARCEL_SIZE / 16;

  logic [OW-1:0]          out_q, out_d, disc_q, disc_d;
  logic [XLEN-1:0]        tag_pc_q [MAX_OUTSTANDING];
  logic [TW-1:0]          tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PARCEL_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0]        fifo_pc_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_mis_q, fifo_err_q;
  logic [FW-1:0]          fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [CW-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                   can_req, accept, take, byp, push, pop, empty;
  logic [XLEN-1:0]        tag_pc;

  function automatic logic [TW-1:0] tag_nxt(input logic [TW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  always_comb begin
    empty = fifo_cnt_q == '0;
    tag_pc = tag_pc_q[tag_rp_q];
    // Credit counts FIFO entries plus responses still owed to the FIFO, so a push never finds it full.
    can_req = rstn & ~if_flush & (int'(out_q) < MAX_OUTSTANDING)
            & (int'(out_q) - int'(disc_q) + int'(fifo_cnt_q) < FIFO_DEPTH);
    accept = can_req & ibus_gnt;
    take = ibus_rvalid & (disc_q == '0) & ~if_flush;
`ifdef RISCV_IFETCH_BYPASS_EN
    byp = empty & ibus_rvalid & (disc_q == '0);
`else
    byp = 1'b0;
`endif
    push = take & ~(byp & ~if_stall);
    pop = ~empty & ~if_stall & ~if_flush;
    out_d = out_q + OW'(accept) - OW'(ibus_rvalid);
    disc_d = if_flush ? out_q - OW'(ibus_rvalid)
           : (ibus_rvalid & (disc_q != '0)) ? disc_q - OW'(1) : disc_q;
    tag_wp_d = if_flush ? '0 : accept ? tag_nxt(tag_wp_q) : tag_wp_q;
    tag_rp_d = if_flush ? '0 : take ? tag_nxt(tag_rp_q) : tag_rp_q;
    fifo_wp_d = if_flush ? '0 : fifo_wp_q + FW'(push);
    fifo_rp_d = if_flush ? '0 : fifo_rp_q + FW'(pop);
    fifo_cnt_d = if_flush ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
    ibus_req = can_req;
    ibus_addr = {if_nxt_pc[XLEN-1:2], 2'b00};
    if_stall_nxt_pc = ~accept;
    if_parcel_valid = {NV{(~empty | byp) & ~if_flush}};
    if_parcel = byp ? ibus_rdata : fifo_data_q[fifo_rp_q];
    if_parcel_pc = byp ? tag_pc : fifo_pc_q[fifo_rp_q];
    if_parcel_misaligned = byp ? |tag_pc[1:0] : fifo_mis_q[fifo_rp_q];
    if_parcel_page_fault = byp ? ibus_err : fifo_err_q[fifo_rp_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= '0;
      disc_q <= '0;
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      fifo_wp_q <= '0;
      fifo_rp_q <= '0;
      fifo_cnt_q <= '0;
      fifo_mis_q <= '0;
      fifo_err_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_pc_q[i] <= PC_INIT;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i] <= PC_INIT;
      end
    end else begin
      out_q <= out_d;
      disc_q <= disc_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
      fifo_wp_q <= fifo_wp_d;
      fifo_rp_q <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (accept) tag_pc_q[tag_wp_q] <= if_nxt_pc;
      if (push) begin
        fifo_data_q[fifo_wp_q] <= ibus_rdata;
        fifo_pc_q[fifo_wp_q] <= tag_pc;
        fifo_mis_q[fifo_wp_q] <= |tag_pc[1:0];
        fifo_err_q[fifo_wp_q] <= ibus_err;
      end
    end
  end

  always_ff @(posedge clk) if (rstn) assert (!(push && !pop && fifo_cnt_q == CW'(FIFO_DEPTH)));
endmodule
